// File: rtl/updown_pkg.sv
// Shared types and helpers for the prescaled up/down counter.
// Holds the state encoding, the default widths and the wrapping step functions.
package updown_pkg;

  localparam int Q_W   = 4;
  localparam int DIV_W = 3;

  typedef enum logic [3:0] {
    S0, S1, S2,  S3,  S4,  S5,  S6,  S7,
    S8, S9, S10, S11, S12, S13, S14, S15
  } state_t;

  // Modulo-16 arithmetic on a 4-bit state gives the 15->0 and 0->15 wraps.
  function automatic state_t f_up(input state_t s);
    return state_t'(s + 4'd1);
  endfunction

  function automatic state_t f_down(input state_t s);
    return state_t'(s - 4'd1);
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Programmable prescaler: produces a one-cycle enable tick every div clocks.
// div values 0 and 1 both give a tick on every cycle.
module clk_div_tick
  import updown_pkg::*;
#(
  parameter int DIV_W_P = DIV_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [DIV_W_P-1:0] div,
  output logic               tick
);

  logic [DIV_W_P-1:0] pcnt_q;
  logic [DIV_W_P-1:0] pcnt_d;

  // Comparing with >= lets a lowered div fire at once instead of waiting for a wrap.
  always_comb begin
    if (div <= DIV_W_P'(1)) tick = 1'b1;
    else                    tick = (pcnt_q >= (div - DIV_W_P'(1)));
  end

  assign pcnt_d = tick ? '0 : pcnt_q + DIV_W_P'(1);

  // NOTE: state registers use non-blocking assignments and clear is in the
  // sensitivity list so it takes effect without a clock edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/updown_prescaled_counter.sv
// 16-state Moore up/down counter advanced only on prescaler ticks.
// clear resets everything asynchronously; reset clears only the counter, synchronously.
module updown_prescaled_counter
  import updown_pkg::*;
#(
  parameter int Q_W_P   = Q_W,
  parameter int DIV_W_P = DIV_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               reset,
  input  logic               ud,
  input  logic [DIV_W_P-1:0] div,
  output logic               tick,
  output logic [Q_W_P-1:0]   q
);

  state_t state_q;
  state_t state_d;

  clk_div_tick #(
    .DIV_W_P (DIV_W_P)
  ) u_div (
    .clk   (clk),
    .clear (clear),
    .div   (div),
    .tick  (tick)
  );

  // NOTE: state_d gets a default before the case so no latch is inferred
  // for the hold branch.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = S0;
    end else begin
      unique case ({tick, ud})
        2'b11:   state_d = f_up(state_q);
        2'b10:   state_d = f_down(state_q);
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S0;
    else       state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: tb/tb_updown_prescaled_counter.sv
// Self-checking bench: directed steps followed by random traffic, checked
// against a cycle-level arithmetic model of the prescaler and counter.
module tb_updown_prescaled_counter;

  logic       clk   = 1'b0;
  logic       clear = 1'b0;
  logic       reset = 1'b0;
  logic       ud    = 1'b1;
  logic [2:0] div   = 3'd0;
  logic       tick;
  logic [3:0] q;

  int passed = 0;
  int total  = 0;

  // Reference model: cycles since the last tick, and the count value.
  int m   = 0;
  int q_m = 0;

  updown_prescaled_counter dut (
    .clk   (clk),
    .clear (clear),
    .reset (reset),
    .ud    (ud),
    .div   (div),
    .tick  (tick),
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic bit tick_f();
    int d = int'(div);
    return (d <= 1) || (m >= d - 1);
  endfunction

  // One clock: check tick before the edge, step the model, check q after it.
  task automatic cycle(input string tag);
    bit t, r, u;
    #1;
    t = tick_f();
    check({tag, ".tick"}, {7'd0, tick}, {7'd0, t});
    r = reset;
    u = ud;
    @(posedge clk);
    m = t ? 0 : m + 1;
    if (r)      q_m = 0;
    else if (t) q_m = u ? (q_m + 1) % 16 : (q_m + 15) % 16;
    #1;
    check({tag, ".q"}, {4'd0, q}, 8'(q_m));
  endtask

  // Mid-cycle clear pulse: q and pcnt must drop without a clock edge.
  task automatic do_clear(input string tag);
    clear = 1'b1;
    #1;
    m   = 0;
    q_m = 0;
    check({tag, ".clr_q"}, {4'd0, q}, 8'd0);
    check({tag, ".clr_pcnt"}, {5'd0, dut.u_div.pcnt_q}, 8'd0);
    clear = 1'b0;
  endtask

  initial begin
    #1;
    // 1: divide-by-1, count up five times
    div = 3'd0; ud = 1'b1; reset = 1'b0;
    do_clear("s1");
    for (int i = 0; i < 5; i++) cycle("s1");
    check("s1.q_is_5", {4'd0, q}, 8'd5);

    // 2: synchronous reset, then count down through the wrap
    reset = 1'b1;
    cycle("s2.reset");
    reset = 1'b0; ud = 1'b0;
    for (int i = 0; i < 5; i++) cycle("s2.down");
    check("s2.q_is_11", {4'd0, q}, 8'd11);

    // 3: divide-by-2 for 20 cycles
    div = 3'd2; ud = 1'b1;
    do_clear("s3");
    for (int i = 0; i < 20; i++) cycle("s3");
    check("s3.q_is_10", {4'd0, q}, 8'd10);

    // 4: sweep div 3..7
    for (int d = 3; d <= 7; d++) begin
      div = 3'(d);
      do_clear("s4");
      for (int i = 0; i < 20; i++) cycle($sformatf("s4.div%0d", d));
      check($sformatf("s4.div%0d.final", d), {4'd0, q}, 8'(20 / d));
    end

    // 5: wrap 15 -> 0 upward, then asynchronous clear between edges
    div = 3'd0;
    do_clear("s5");
    ud = 1'b0;
    cycle("s5.to15");
    ud = 1'b1;
    cycle("s5.wrap");
    check("s5.q_is_0", {4'd0, q}, 8'd0);
    div = 3'd5;
    for (int i = 0; i < 3; i++) cycle("s5.run");
    do_clear("s5.mid");

    // 6: lower div from 7 to 3 while pcnt = 5
    div = 3'd7; ud = 1'b1;
    do_clear("s6");
    for (int i = 0; i < 5; i++) cycle("s6.pre");
    check("s6.pcnt_is_5", {5'd0, dut.u_div.pcnt_q}, 8'd5);
    div = 3'd3;
    #1;
    check("s6.tick_now", {7'd0, tick}, 8'd1);
    cycle("s6.switch");
    check("s6.pcnt_zero", {5'd0, dut.u_div.pcnt_q}, 8'd0);
    for (int i = 0; i < 6; i++) cycle("s6.div3");
    for (int i = 0; i < 8 && !tick_f(); i++) cycle("s6.seek");
    reset = 1'b1;
    cycle("s6.reset_tick");
    check("s6.q_reset", {4'd0, q}, 8'd0);
    reset = 1'b0;

    // 7: random traffic
    for (int i = 0; i < 400; i++) begin
      ud    = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)  div = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) do_clear("rnd");
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
